// File: rtl/return_addr_stack.sv
// Circular return-address stack for the CPU call/return path.
// A push stores the return address and a pop restores the entry beneath it.
// A push and pop in the same cycle replaces the top entry.
// Optional feature: define RAS_HWM_EN to track the high-water occupancy mark.
module return_addr_stack #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic [ADDR_W-1:0]     data_in,
    output logic [ADDR_W-1:0]     data_out,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   high_water
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DepthCount = CW'(DEPTH);

    logic [ADDR_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_W-1:0]     top_q, top_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  ovf_evt, udf_evt;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [DEPTH_LOG2-1:0] below_idx;
    logic                  is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DepthCount);
    // Entry beneath the current top; becomes the new top on a pop.
    assign below_idx = wp_q - DEPTH_LOG2'(2);

    // Next-state decode; flush outranks push/pop.
    always_comb begin
        wp_d      = wp_q;
        count_d   = count_q;
        top_d     = top_q;
        mem_we    = 1'b0;
        mem_waddr = wp_q;
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;
        if (flush) begin
            count_d = '0;
            top_d   = '0;
        end else if (push && pop && !is_empty) begin
            mem_we    = 1'b1;
            mem_waddr = wp_q - DEPTH_LOG2'(1);
            top_d     = data_in;
        end else if (push) begin
            // Also covers push+pop on an empty stack.
            mem_we = 1'b1;
            wp_d   = wp_q + DEPTH_LOG2'(1);
            top_d  = data_in;
            if (is_full) begin
                ovf_evt = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                udf_evt = 1'b1;
            end else begin
                wp_d    = wp_q - DEPTH_LOG2'(1);
                count_d = count_q - CW'(1);
                top_d   = (count_q == CW'(1)) ? '0 : mem[below_idx];
            end
        end
        ovf_d = ovf_evt | (ovf_q & ~err_clr);
        udf_d = udf_evt | (udf_q & ~err_clr);
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= data_in;
        end
    end

`ifdef RAS_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    // High-water mark: err_clr rebases it on the next count.
    always_comb begin
        hwm_d = hwm_q;
        if (err_clr) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    // High-water register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign high_water = hwm_q;
`else
    assign high_water = '0;
`endif

    assign data_out  = top_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Randomised bench for return_addr_stack (4-deep, 16-bit) with a queue-based model.
module tb_return_addr_stack;

    localparam int unsigned AW    = 16;
    localparam int unsigned DL2   = 2;
    localparam int unsigned DEPTH = 1 << DL2;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic          flush;
    logic          err_clr;
    logic [AW-1:0] data_in;
    logic [AW-1:0] data_out;
    logic [DL2:0]  count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic [DL2:0]  high_water;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the stack as a queue (back = top of stack).
    logic [AW-1:0] mq[$];
    bit            m_ovf;
    bit            m_udf;
    int            m_hwm;

    return_addr_stack #(
        .ADDR_W     (AW),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .err_clr    (err_clr),
        .data_in    (data_in),
        .data_out   (data_out),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow),
        .high_water (high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_apply(input bit r, input bit f, input bit pu, input bit po,
                               input bit ec, input logic [AW-1:0] d);
        bit ovf_e;
        bit udf_e;
        logic [AW-1:0] tmp;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_hwm = 0;
            return;
        end
        ovf_e = 1'b0;
        udf_e = 1'b0;
        if (f) begin
            mq.delete();
        end else if (pu && po && mq.size() > 0) begin
            mq[mq.size() - 1] = d;
        end else if (pu) begin
            if (mq.size() == DEPTH) begin
                tmp   = mq.pop_front();
                ovf_e = 1'b1;
            end
            mq.push_back(d);
        end else if (po) begin
            if (mq.size() == 0) udf_e = 1'b1;
            else tmp = mq.pop_back();
        end
        m_ovf = ovf_e | (m_ovf & !ec);
        m_udf = udf_e | (m_udf & !ec);
        if (ec) m_hwm = mq.size();
        else if (mq.size() > m_hwm) m_hwm = mq.size();
    endtask

    task automatic compare_all();
        logic [AW-1:0] exp_top;
        int exp_hwm;
        exp_top = (mq.size() > 0) ? mq[mq.size() - 1] : '0;
`ifdef RAS_HWM_EN
        exp_hwm = m_hwm;
`else
        exp_hwm = 0;
`endif
        check("data_out",   32'(data_out),   32'(exp_top));
        check("count",      32'(count),      32'(mq.size()));
        check("empty",      32'(empty),      32'(mq.size() == 0));
        check("full",       32'(full),       32'(mq.size() == DEPTH));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("underflow",  32'(underflow),  32'(m_udf));
        check("high_water", 32'(high_water), 32'(exp_hwm));
    endtask

    // One clock: drive, update model at the edge, sample 1 ns later.
    task automatic step(input bit r, input bit f, input bit pu, input bit po,
                        input bit ec, input logic [AW-1:0] d);
        rst     = r;
        flush   = f;
        push    = pu;
        pop     = po;
        err_clr = ec;
        data_in = d;
        @(posedge clk);
        model_apply(r, f, pu, po, ec, d);
        #1;
        compare_all();
    endtask

    task automatic do_push(input logic [AW-1:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; data_in = '0;

        // Reset state.
        do_rst();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);

        // Basic push/pop ordering.
        do_push(16'h1111); do_push(16'h2222); do_push(16'h3333);
        check("tp1_count", 32'(count), 32'd3);
        check("tp1_top", 32'(data_out), 32'h3333);
        do_pop(); check("tp1_pop1", 32'(data_out), 32'h2222);
        do_pop(); check("tp1_pop2", 32'(data_out), 32'h1111);
        do_pop(); check("tp1_pop3", 32'(data_out), 32'h0);
        check("tp1_empty", 32'(empty), 32'd1);
        check("tp1_flags", 32'({overflow, underflow}), 32'd0);

        // Overflow with wrap: oldest entry lost.
        do_rst();
        for (int i = 0; i < 5; i++) begin
            do_push(16'(16'hA0 + i));
            if (i == 3) check("tp2_full", 32'(full), 32'd1);
        end
        check("tp2_ovf", 32'(overflow), 32'd1);
        check("tp2_count", 32'(count), 32'd4);
        do_pop(); check("tp2_pop1", 32'(data_out), 32'hA3);
        do_pop(); check("tp2_pop2", 32'(data_out), 32'hA2);
        do_pop(); check("tp2_pop3", 32'(data_out), 32'hA1);
        do_pop(); check("tp2_pop4", 32'(data_out), 32'h0);
        check("tp2_empty", 32'(empty), 32'd1);

        // Underflow, err_clr losing to a coincident event.
        do_rst();
        do_pop();
        check("tp3_udf", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        check("tp3_udf_set_wins", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("tp3_udf_clr", 32'(underflow), 32'd0);

        // Replace-top.
        do_rst();
        do_push(16'h0100); do_push(16'h0200);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0300);
        check("tp4_count", 32'(count), 32'd2);
        check("tp4_top", 32'(data_out), 32'h0300);
        do_pop(); check("tp4_pop", 32'(data_out), 32'h0100);

        // Flush beats a coincident push.
        do_rst();
        do_push(16'h0001); do_push(16'h0002); do_push(16'h0003);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
        check("tp5_count", 32'(count), 32'd0);
        check("tp5_top", 32'(data_out), 32'd0);
`ifdef RAS_HWM_EN
        check("tp5_hwm_keep", 32'(high_water), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        do_push(16'h0004);
        check("tp5_hwm_rebase", 32'(high_water), 32'd1);
`endif

        // Reset beats a coincident pop.
        do_rst();
        do_push(16'h0005); do_push(16'h0006);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("tp6_count", 32'(count), 32'd0);
        check("tp6_top", 32'(data_out), 32'd0);
        check("tp6_empty", 32'(empty), 32'd1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            bit b_rst, b_fl, b_pu, b_po, b_ec;
            r     = $urandom_range(0, 99);
            b_rst = (r < 2);
            b_fl  = (r >= 2 && r < 6);
            b_pu  = ($urandom_range(0, 99) < 55);
            b_po  = ($urandom_range(0, 99) < 50);
            b_ec  = !b_fl && ($urandom_range(0, 99) < 5);
            step(b_rst, b_fl, b_pu, b_po, b_ec, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
